// File: rtl/n64adv_igr_decoder_pkg.sv
// Shared constants for the in-game-routine decoder: button combos, combo ids, FSM states.
// Button bits: 0 A, 1 B, 2 Z, 3 St, 4 Du, 5 Dd, 6 Dl, 7 Dr, 8/9 unused, 10 L, 11 R, 12 Cu, 13 Cd, 14 Cl, 15 Cr.
package n64adv_igr_decoder_pkg;

  localparam logic [15:0] IGR_MASK       = 16'hFCFF;
  localparam logic [15:0] IGR_RESET      = 16'h080F; // A+B+Z+St+R
  localparam logic [15:0] IGR_DEBLUR_ON  = 16'h280C; // Z+St+R+Cd
  localparam logic [15:0] IGR_DEBLUR_OFF = 16'h180C; // Z+St+R+Cu
  localparam logic [15:0] IGR_15BIT      = 16'h480C; // Z+St+R+Cl

  typedef enum logic [2:0] {
    CMB_NONE       = 3'd0,
    CMB_RESET      = 3'd1,
    CMB_DEBLUR_ON  = 3'd2,
    CMB_DEBLUR_OFF = 3'd3,
    CMB_15BIT      = 3'd4
  } combo_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FIRED = 2'b10
  } igr_state_t;

  // Pulse vector order: {mode15b_tgl, deblur_off, deblur_on, igr_nrst}
  function automatic logic [3:0] combo_pulse(input combo_t c);
    logic [3:0] p;
    p = 4'b0000;
    case (c)
      CMB_RESET:      p = 4'b0001;
      CMB_DEBLUR_ON:  p = 4'b0010;
      CMB_DEBLUR_OFF: p = 4'b0100;
      CMB_15BIT:      p = 4'b1000;
      default:        p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/n64adv_igr_match.sv
// Combinational classifier: masked controller buttons -> combo id (exact match only).
module n64adv_igr_match
  import n64adv_igr_decoder_pkg::*;
(
  input  logic [15:0] buttons,
  output combo_t      combo
);

  logic [15:0] masked;

  always_comb begin
    masked = buttons & IGR_MASK;
    combo  = CMB_NONE;
    if (masked == IGR_RESET)           combo = CMB_RESET;
    else if (masked == IGR_DEBLUR_ON)  combo = CMB_DEBLUR_ON;
    else if (masked == IGR_DEBLUR_OFF) combo = CMB_DEBLUR_OFF;
    else if (masked == IGR_15BIT)      combo = CMB_15BIT;
  end

endmodule

// File: rtl/n64adv_igr_decoder.sv
// In-game-routine decoder: fires one-cycle command pulses once a button combo has been
// held for HOLD_POLLS consecutive controller polls; re-arms only after the combo is released.
module n64adv_igr_decoder
  import n64adv_igr_decoder_pkg::*;
#(
  parameter logic [5:0]  HOLD_POLLS  = 6'd30,
  parameter logic [19:0] TIMEOUT_CYC = 20'd400000
)(
  input  logic        CLK_4M,
  input  logic        nSRST_4M,
  // ctrl_data_valid is a one-cycle strobe with no back-pressure: ctrl_data is only
  // meaningful in the cycle the strobe is high, and every strobe is consumed.
  input  logic        ctrl_data_valid,
  input  logic [31:0] ctrl_data,
  input  logic        use_igr,
  output logic        igr_nrst_pulse,
  output logic        deblur_on_pulse,
  output logic        deblur_off_pulse,
  output logic        mode15b_tgl_pulse,
  output logic [1:0]  igr_state
);

  localparam logic [19:0] TMO_MAX = '1;

  igr_state_t  state, state_nxt;
  combo_t      combo_q, combo_nxt, combo_in;
  logic [5:0]  hold_cnt, hold_nxt, hold_inc;
  logic [19:0] tmo_cnt, tmo_nxt, tmo_inc;
  logic [3:0]  pulse_q, pulse_nxt;
  logic        fire;
  logic        unused_stick;

  // Stick axes never take part in combo matching.
  assign unused_stick = ^ctrl_data[31:16];

  n64adv_igr_match u_match (
    .buttons (ctrl_data[15:0]),
    .combo   (combo_in)
  );

  assign hold_inc = (hold_cnt == 6'd63) ? hold_cnt : hold_cnt + 6'd1;
  assign tmo_inc  = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 20'd1;

  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      state    <= ST_IDLE;
      combo_q  <= CMB_NONE;
      hold_cnt <= 6'd0;
      tmo_cnt  <= 20'd0;
      pulse_q  <= 4'b0000;
    end else begin
      state    <= state_nxt;
      combo_q  <= combo_nxt;
      hold_cnt <= hold_nxt;
      tmo_cnt  <= tmo_nxt;
      pulse_q  <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    combo_nxt = combo_q;
    hold_nxt  = hold_cnt;
    tmo_nxt   = tmo_cnt;
    fire      = 1'b0;
    pulse_nxt = 4'b0000;

    if (!use_igr) begin
      state_nxt = ST_IDLE;
      combo_nxt = CMB_NONE;
      hold_nxt  = 6'd0;
      tmo_nxt   = 20'd0;
    end else if (ctrl_data_valid) begin
      tmo_nxt = 20'd0;
      case (state)
        ST_IDLE: begin
          if (combo_in != CMB_NONE) begin
            combo_nxt = combo_in;
            hold_nxt  = 6'd1;
            if (HOLD_POLLS == 6'd1) begin
              fire      = 1'b1;
              state_nxt = ST_FIRED;
            end else begin
              state_nxt = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (combo_in == CMB_NONE) begin
            state_nxt = ST_IDLE;
            hold_nxt  = 6'd0;
          end else if (combo_in != combo_q) begin
            combo_nxt = combo_in;
            hold_nxt  = 6'd1;
          end else begin
            hold_nxt = hold_inc;
            if (hold_inc == HOLD_POLLS) begin
              fire      = 1'b1;
              state_nxt = ST_FIRED;
            end
          end
        end
        ST_FIRED: begin
          // Holding the combo keeps us parked here; any change re-arms from idle.
          if (combo_in != combo_q) begin
            state_nxt = ST_IDLE;
            hold_nxt  = 6'd0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          hold_nxt  = 6'd0;
        end
      endcase
    end else begin
      tmo_nxt = tmo_inc;
      if (state != ST_IDLE && tmo_inc >= TIMEOUT_CYC) begin
        state_nxt = ST_IDLE;
        hold_nxt  = 6'd0;
      end
    end

    if (fire) pulse_nxt = combo_pulse(combo_nxt);
  end

  assign igr_nrst_pulse    = pulse_q[0];
  assign deblur_on_pulse   = pulse_q[1];
  assign deblur_off_pulse  = pulse_q[2];
  assign mode15b_tgl_pulse = pulse_q[3];
  assign igr_state         = state;

endmodule

// File: tb/tb_n64adv_igr_decoder.sv
// Bench for n64adv_igr_decoder: directed combo scenarios plus randomized polling, checked
// against a run-length model of the hold/fire/release/timeout rules.
module tb_n64adv_igr_decoder;

  localparam int HOLD = 30;
  localparam int TMO  = 1000;

  localparam logic [15:0] B_RST = 16'h080F;
  localparam logic [15:0] B_ON  = 16'h280C;
  localparam logic [15:0] B_OFF = 16'h180C;
  localparam logic [15:0] B_15  = 16'h480C;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = 32'd0;
  logic        use_igr = 1'b1;
  logic        use_req = 1'b1;
  logic        p_rst, p_on, p_off, p_15;
  logic [1:0]  st;

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse [4];

  // reference model state
  int         m_cur, m_run, m_idle;
  bit         m_fired;
  logic [3:0] m_pulse;
  logic [3:0] exp_q[$];

  n64adv_igr_decoder #(.HOLD_POLLS(6'd30), .TIMEOUT_CYC(20'd1000)) dut (
    .CLK_4M            (clk),
    .nSRST_4M          (nrst),
    .ctrl_data_valid   (valid),
    .ctrl_data         (data),
    .use_igr           (use_igr),
    .igr_nrst_pulse    (p_rst),
    .deblur_on_pulse   (p_on),
    .deblur_off_pulse  (p_off),
    .mode15b_tgl_pulse (p_15),
    .igr_state         (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cls(input logic [15:0] b);
    logic [15:0] m;
    m = b & 16'hFCFF;
    if (m == B_RST) return 1;
    if (m == B_ON)  return 2;
    if (m == B_OFF) return 3;
    if (m == B_15)  return 4;
    return 0;
  endfunction

  function automatic logic [31:0] mk(input logic [15:0] btn);
    logic [31:0] r;
    r = $urandom();
    return {r[31:16], btn[15:10], r[9:8], btn[7:0]};
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_run == 0) return 2'b00;
    return m_fired ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_run = 0; m_idle = 0; m_fired = 0; m_pulse = 4'b0;
    exp_q.delete();
  endtask

  task automatic model_fire();
    m_fired = 1;
    m_pulse = 4'b0001 << (m_cur - 1);
    exp_q.push_back(m_pulse);
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic u);
    int c;
    m_pulse = 4'b0;
    if (!u) begin
      m_run = 0; m_fired = 0; m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      c = cls(d[15:0]);
      if (m_run == 0) begin
        if (c != 0) begin
          m_cur = c; m_run = 1;
          if (HOLD == 1) model_fire();
        end
      end else if (m_fired) begin
        if (c != m_cur) begin m_run = 0; m_fired = 0; end
      end else if (c == 0) begin
        m_run = 0;
      end else if (c != m_cur) begin
        m_cur = c; m_run = 1;
      end else begin
        m_run++;
        if (m_run == HOLD) model_fire();
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO) begin m_run = 0; m_fired = 0; end
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the posedge.
  task automatic cycle(input logic v, input logic [31:0] d);
    logic [3:0] vec;
    @(negedge clk);
    valid = v; data = d; use_igr = use_req;
    @(posedge clk);
    #1;
    model_step(v, d, use_req);
    vec = {p_15, p_off, p_on, p_rst};
    chk("state", {30'd0, st}, {30'd0, exp_state()});
    chk("pulse_timing", {28'd0, vec}, {28'd0, m_pulse});
    if (vec != 4'b0) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {28'd0, vec}, 32'd0);
      else chk("pulse_order", {28'd0, vec}, {28'd0, exp_q.pop_front()});
    end
    for (int k = 0; k < 4; k++) if (vec[k]) n_pulse[k]++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, $urandom());
  endtask

  task automatic poll(input logic [15:0] btn);
    idle($urandom_range(0, 3));
    cycle(1'b1, mk(btn));
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 4; k++) n_pulse[k] = 0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    nrst = 1'b0;
    valid = 1'b0;
    #1;
    chk({tag, "_outs"}, {27'd0, st, p_15, p_off, p_on, p_rst}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  logic [15:0] seg_btn [6];

  initial begin
    model_reset();
    clr_counts();
    #1;
    chk("reset_state", {30'd0, st}, 32'd0);
    chk("reset_pulses", {28'd0, p_15, p_off, p_on, p_rst}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    // 30 polls of the reset combo: pulse right after the 30th
    for (int i = 0; i < 30; i++) begin
      poll(B_RST);
      if (i == 28) chk("rst_29_armed", {30'd0, st}, 32'd1);
    end
    chk("rst_pulse_after_30", {31'd0, p_rst}, 32'd1);
    idle(1);
    chk("rst_pulse_one_cycle", {31'd0, p_rst}, 32'd0);
    chk("rst_pulse_count", n_pulse[0], 32'd1);
    poll(16'h0000);
    chk("rst_release_idle", {30'd0, st}, 32'd0);

    // 29 polls then release: nothing fires
    clr_counts();
    for (int i = 0; i < 29; i++) poll(B_RST);
    poll(16'h0000);
    chk("rst29_no_pulse", n_pulse[0], 32'd0);
    chk("rst29_idle", {30'd0, st}, 32'd0);

    // long hold fires only once
    clr_counts();
    for (int i = 0; i < 100; i++) poll(B_ON);
    chk("on_single_pulse", n_pulse[1], 32'd1);
    chk("on_fired_held", {30'd0, st}, 32'd2);
    poll(16'h0000);
    chk("on_release_idle", {30'd0, st}, 32'd0);

    // combo switch restarts the hold count
    clr_counts();
    for (int i = 0; i < 20; i++) poll(B_15);
    for (int i = 0; i < 30; i++) poll(B_OFF);
    chk("switch_off_after_50", {31'd0, p_off}, 32'd1);
    chk("switch_off_count", n_pulse[2], 32'd1);
    chk("switch_no_15b", n_pulse[3], 32'd0);
    poll(16'h0000);

    // timeout while armed, then restart from one
    clr_counts();
    for (int i = 0; i < 10; i++) poll(B_RST);
    idle(TMO + 2);
    chk("timeout_idle", {30'd0, st}, 32'd0);
    for (int i = 0; i < 29; i++) poll(B_RST);
    chk("timeout_restart_no_pulse", n_pulse[0], 32'd0);
    poll(B_RST);
    chk("timeout_restart_fire", n_pulse[0], 32'd1);
    poll(16'h0000);

    // disabled: nothing fires
    clr_counts();
    use_req = 1'b0;
    for (int i = 0; i < 40; i++) poll(B_RST);
    chk("disabled_no_pulse", n_pulse[0], 32'd0);
    chk("disabled_idle", {30'd0, st}, 32'd0);
    use_req = 1'b1;

    // disable lands on the completing strobe
    clr_counts();
    for (int i = 0; i < 29; i++) poll(B_RST);
    use_req = 1'b0;
    cycle(1'b1, mk(B_RST));
    chk("drop_on_fire_no_pulse", n_pulse[0], 32'd0);
    use_req = 1'b1;
    poll(B_RST);
    chk("drop_restart_armed", {30'd0, st}, 32'd1);
    poll(16'h0000);

    // reset in the middle of arming
    for (int i = 0; i < 10; i++) poll(B_15);
    async_reset("rst_mid_armed");
    // reset while a pulse is high
    for (int i = 0; i < 30; i++) poll(B_ON);
    async_reset("rst_kills_pulse");
    poll(B_ON);
    chk("after_reset_armed", {30'd0, st}, 32'd1);

    // randomized segments of held buttons and long gaps
    seg_btn[0] = B_RST; seg_btn[1] = B_ON; seg_btn[2] = B_OFF;
    seg_btn[3] = B_15;  seg_btn[4] = 16'h0000;
    for (int s = 0; s < 24; s++) begin
      int sel;
      int len;
      seg_btn[5] = 16'($urandom());
      sel = $urandom_range(0, 6);
      if (sel == 6) begin
        idle($urandom_range(TMO - 20, TMO + 20));
      end else begin
        len = $urandom_range(1, 45);
        for (int i = 0; i < len; i++) poll(seg_btn[sel]);
      end
    end
    idle(2);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
